sim_harness_ctrl: RTL and testbench

SIM_HARNESS_CTRL -- requirements
Module: sim_harness_ctrl

---
 rtl/sim_harness_ctrl.sv | 159 +++++++++++++++
 tb/tb_sim_harness_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sim_harness_ctrl.sv
// Simulation harness controller: synchronises reset release to the DUT, counts cycles and
// latches a sticky pass / fail / timeout verdict from per-channel DUT status.
module sim_harness_ctrl #(
  parameter int unsigned       NUM_CH     = 4,
  parameter int unsigned       CNT_W      = 32,
  parameter int unsigned       MAX_CYC    = 1000,
  parameter int unsigned       RST_STAGES = 2,
  parameter int unsigned       RST_HOLD   = 4,
  parameter logic [NUM_CH-1:0] CH_EN      = '1
) (
  input  logic              clk,
  input  logic              reset_async,
  input  logic [NUM_CH-1:0] ch_passed,
  input  logic [NUM_CH-1:0] ch_failed,
  output logic              reset,
  output logic [CNT_W-1:0]  cyc_cnt,
  output logic              passed,
  output logic              failed,
  output logic              timeout,
  output logic              done,
  output logic [4:0]        fail_ch,
  output logic [CNT_W-1:0]  end_cyc
);

  localparam int unsigned HoldW = (RST_HOLD > 0) ? $clog2(RST_HOLD + 1) : 1;

  typedef enum logic [2:0] {
    StHold,
    StRun,
    StPass,
    StFail,
    StTmo
  } state_e;

  // Reset release: synchroniser chain, then a hold counter before the DUT sees reset drop.
  logic [RST_STAGES-1:0] sync_q;
  logic [HoldW-1:0]      hold_cnt_q, hold_cnt_d;
  logic                  sync_done, hold_done;

  always_ff @(posedge clk or negedge reset_async) begin
    if (!reset_async) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[RST_STAGES-2:0], 1'b1};
    end
  end

  assign sync_done = sync_q[RST_STAGES-1];
  assign hold_done = (hold_cnt_q == HoldW'(RST_HOLD));

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (sync_done && !hold_done) begin
      hold_cnt_d = hold_cnt_q + HoldW'(1);
    end
  end

  assign reset = ~(sync_done & hold_done);

  // Verdict FSM
  state_e             state_q, state_d;
  logic [NUM_CH-1:0]  seen_q, seen_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   end_q, end_d;
  logic [4:0]         fail_ch_q, fail_ch_d;
  logic               passed_q, failed_q, timeout_q, done_q;
  logic               passed_d, failed_d, timeout_d, done_d;
  logic [NUM_CH-1:0]  fail_hit;
  logic               pass_hit, tmo_hit;
  logic [4:0]         low_idx;

  always_comb begin
    fail_hit = ch_failed & CH_EN;
    seen_d   = seen_q;
    if (state_q == StRun) begin
      seen_d = seen_q | ch_passed;
    end
    pass_hit = ((seen_d & CH_EN) == CH_EN);
    tmo_hit  = (cnt_q == CNT_W'(MAX_CYC));
    // Descending scan so the lowest failing index wins.
    low_idx  = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (fail_hit[i]) begin
        low_idx = 5'(i);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    end_d     = end_q;
    fail_ch_d = fail_ch_q;
    unique case (state_q)
      StHold: begin
        if (!reset) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (|fail_hit) begin
          state_d   = StFail;
          fail_ch_d = low_idx;
        end else if (pass_hit) begin
          state_d = StPass;
        end else if (tmo_hit) begin
          state_d = StTmo;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        // Terminal states hold until reset_async.
      end
    endcase
    if ((state_q == StRun) && (state_d != StRun)) begin
      end_d = cnt_q;
    end
    passed_d  = (state_d == StPass);
    failed_d  = (state_d == StFail) || (state_d == StTmo);
    timeout_d = (state_d == StTmo);
    done_d    = (state_d == StPass) || (state_d == StFail) || (state_d == StTmo);
  end

  always_ff @(posedge clk or negedge reset_async) begin
    if (!reset_async) begin
      hold_cnt_q <= '0;
      state_q    <= StHold;
      seen_q     <= '0;
      cnt_q      <= CNT_W'(1);
      end_q      <= '0;
      fail_ch_q  <= '0;
      passed_q   <= 1'b0;
      failed_q   <= 1'b0;
      timeout_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      state_q    <= state_d;
      seen_q     <= seen_d;
      cnt_q      <= cnt_d;
      end_q      <= end_d;
      fail_ch_q  <= fail_ch_d;
      passed_q   <= passed_d;
      failed_q   <= failed_d;
      timeout_q  <= timeout_d;
      done_q     <= done_d;
    end
  end

  assign cyc_cnt = cnt_q;
  assign end_cyc = end_q;
  assign fail_ch = fail_ch_q;
  assign passed  = passed_q;
  assign failed  = failed_q;
  assign timeout = timeout_q;
  assign done    = done_q;

endmodule

// File: tb/tb_sim_harness_ctrl.sv
// Randomised and directed bench for sim_harness_ctrl: two instances (defaults, and a
// two-channel / short-timeout variant) share stimulus; verdicts go through a scoreboard.
module tb_sim_harness_ctrl;

  localparam int unsigned MAIN_MAX = 1000;
  localparam int unsigned ALT_MAX  = 50;
  localparam logic [3:0]  ALT_EN   = 4'b0011;
  localparam int          PLAN_LEN = 1004;

  typedef struct packed {
    logic        passed;
    logic        failed;
    logic        timeout;
    logic [4:0]  fail_ch;
    logic [31:0] end_cyc;
  } verdict_t;

  logic        clk = 1'b0;
  logic        reset_async = 1'b0;
  logic [3:0]  ch_passed = '0;
  logic [3:0]  ch_failed = '0;

  logic        m_reset, m_passed, m_failed, m_timeout, m_done;
  logic [31:0] m_cyc_cnt, m_end_cyc;
  logic [4:0]  m_fail_ch;
  logic        a_reset, a_passed, a_failed, a_timeout, a_done;
  logic [31:0] a_cyc_cnt, a_end_cyc;
  logic [4:0]  a_fail_ch;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [3:0] pass_plan [PLAN_LEN];
  logic [3:0] fail_plan [PLAN_LEN];
  verdict_t   exp_main [$];
  verdict_t   exp_alt [$];
  logic       m_done_prev = 1'b0;
  logic       a_done_prev = 1'b0;

  always #5 clk = ~clk;

  sim_harness_ctrl u_main (
    .clk         (clk),
    .reset_async (reset_async),
    .ch_passed   (ch_passed),
    .ch_failed   (ch_failed),
    .reset       (m_reset),
    .cyc_cnt     (m_cyc_cnt),
    .passed      (m_passed),
    .failed      (m_failed),
    .timeout     (m_timeout),
    .done        (m_done),
    .fail_ch     (m_fail_ch),
    .end_cyc     (m_end_cyc)
  );

  sim_harness_ctrl #(
    .MAX_CYC (ALT_MAX),
    .CH_EN   (ALT_EN)
  ) u_alt (
    .clk         (clk),
    .reset_async (reset_async),
    .ch_passed   (ch_passed),
    .ch_failed   (ch_failed),
    .reset       (a_reset),
    .cyc_cnt     (a_cyc_cnt),
    .passed      (a_passed),
    .failed      (a_failed),
    .timeout     (a_timeout),
    .done        (a_done),
    .fail_ch     (a_fail_ch),
    .end_cyc     (a_end_cyc)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: walk the plan cycle by cycle applying fail > pass > timeout.
  function automatic verdict_t model(input logic [3:0] en, input int unsigned max_cyc);
    verdict_t   v;
    logic [3:0] seen;
    v    = '0;
    seen = '0;
    for (int n = 1; n <= int'(max_cyc); n++) begin
      seen = seen | pass_plan[n];
      if ((fail_plan[n] & en) != 4'b0) begin
        v.failed  = 1'b1;
        v.end_cyc = 32'(n);
        for (int i = 3; i >= 0; i--) begin
          if (fail_plan[n][i] && en[i]) v.fail_ch = 5'(i);
        end
        return v;
      end
      if ((seen & en) == en) begin
        v.passed  = 1'b1;
        v.end_cyc = 32'(n);
        return v;
      end
    end
    v.failed  = 1'b1;
    v.timeout = 1'b1;
    v.end_cyc = 32'(max_cyc);
    return v;
  endfunction

  task automatic check_verdict(input string tag, input verdict_t e, input logic p, input logic f,
                               input logic t, input logic [4:0] fc, input logic [31:0] ec,
                               input logic [31:0] cc);
    chk({tag, ".passed"}, 64'(p), 64'(e.passed));
    chk({tag, ".failed"}, 64'(f), 64'(e.failed));
    chk({tag, ".timeout"}, 64'(t), 64'(e.timeout));
    chk({tag, ".fail_ch"}, 64'(fc), 64'(e.fail_ch));
    chk({tag, ".end_cyc"}, 64'(ec), 64'(e.end_cyc));
    chk({tag, ".cyc_cnt_frozen"}, 64'(cc), 64'(e.end_cyc));
  endtask

  // Monitor: pop one expected verdict whenever done rises.
  always @(negedge clk) begin
    if (m_done && !m_done_prev) begin
      chk("main.verdict_expected", 64'(exp_main.size() > 0), 64'd1);
      if (exp_main.size() > 0)
        check_verdict("main", exp_main.pop_front(), m_passed, m_failed, m_timeout, m_fail_ch,
                      m_end_cyc, m_cyc_cnt);
    end
    if (a_done && !a_done_prev) begin
      chk("alt.verdict_expected", 64'(exp_alt.size() > 0), 64'd1);
      if (exp_alt.size() > 0)
        check_verdict("alt", exp_alt.pop_front(), a_passed, a_failed, a_timeout, a_fail_ch,
                      a_end_cyc, a_cyc_cnt);
    end
    m_done_prev <= m_done;
    a_done_prev <= a_done;
  end

  task automatic check_cleared();
    chk("main.rst_flags", 64'({m_reset, m_passed, m_failed, m_timeout, m_done, m_fail_ch}),
        64'(10'b10000_00000));
    chk("main.rst_cyc_cnt", 64'(m_cyc_cnt), 64'd1);
    chk("main.rst_end_cyc", 64'(m_end_cyc), 64'd0);
    chk("alt.rst_flags", 64'({a_reset, a_passed, a_failed, a_timeout, a_done, a_fail_ch}),
        64'(10'b10000_00000));
    chk("alt.rst_cyc_cnt", 64'(a_cyc_cnt), 64'd1);
    chk("alt.rst_end_cyc", 64'(a_end_cyc), 64'd0);
  endtask

  task automatic clear_plan();
    for (int i = 0; i < PLAN_LEN; i++) begin
      pass_plan[i] = '0;
      fail_plan[i] = '0;
    end
  endtask

  task automatic random_plan();
    int unsigned pr, fr;
    pr = $urandom_range(2, 6);
    case ($urandom_range(0, 2))
      0:       fr = 0;
      1:       fr = 40;
      default: fr = 200;
    endcase
    for (int i = 0; i < PLAN_LEN; i++) begin
      for (int b = 0; b < 4; b++) begin
        pass_plan[i][b] = ($urandom_range(0, pr - 1) == 0);
        fail_plan[i][b] = (fr != 0) && ($urandom_range(0, fr - 1) == 0);
      end
    end
  endtask

  // Reset, release, then drive plan[n] during RUN cycle n; abort_at>0 cuts the run short.
  task automatic run_test(input bit short_rst, input int unsigned abort_at);
    verdict_t    em, ea;
    int unsigned last;
    em = model(4'hF, MAIN_MAX);
    ea = model(ALT_EN, ALT_MAX);
    last = ((em.end_cyc > ea.end_cyc) ? em.end_cyc : ea.end_cyc) + 3;
    // Inputs after both verdicts are junk that must be ignored.
    for (int i = int'(last) - 2; i < PLAN_LEN; i++) begin
      pass_plan[i] = 4'($urandom);
      fail_plan[i] = 4'($urandom);
    end
    @(negedge clk);
    reset_async = 1'b0;
    ch_passed   = 4'($urandom);
    ch_failed   = 4'($urandom);
    #1;
    check_cleared();
    if (short_rst) begin
      #1 reset_async = 1'b1;
    end else begin
      @(posedge clk);
      @(negedge clk);
      reset_async = 1'b1;
    end
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk("main.reset_release", 64'(m_reset), 64'(k < 6));
      chk("alt.reset_release", 64'(a_reset), 64'(k < 6));
      ch_passed = 4'($urandom);
      ch_failed = 4'($urandom);
    end
    chk("main.cyc_cnt_hold", 64'(m_cyc_cnt), 64'd1);
    if (abort_at == 0) begin
      exp_main.push_back(em);
      exp_alt.push_back(ea);
    end else begin
      last = abort_at;
    end
    for (int n = 1; n <= int'(last); n++) begin
      @(posedge clk);
      @(negedge clk);
      chk("main.cyc_cnt", 64'(m_cyc_cnt), 64'((32'(n) < em.end_cyc) ? 32'(n) : em.end_cyc));
      chk("alt.cyc_cnt", 64'(a_cyc_cnt), 64'((32'(n) < ea.end_cyc) ? 32'(n) : ea.end_cyc));
      ch_passed = pass_plan[n];
      ch_failed = fail_plan[n];
    end
    chk("main.verdict_seen", 64'(exp_main.size()), 64'd0);
    chk("alt.verdict_seen", 64'(exp_alt.size()), 64'd0);
    exp_main.delete();
    exp_alt.delete();
  endtask

  initial begin
    // Staggered pass pulses.
    clear_plan();
    pass_plan[10] = 4'b0001;
    pass_plan[12] = 4'b0010;
    pass_plan[14] = 4'b0100;
    pass_plan[20] = 4'b1000;
    run_test(1'b0, 0);
    // Fail beats pass in the same cycle.
    clear_plan();
    pass_plan[15] = 4'b1111;
    fail_plan[15] = 4'b0110;
    run_test(1'b0, 0);
    // No stimulus: timeouts.
    clear_plan();
    run_test(1'b0, 0);
    // Disabled channel fail ignored by the alt instance.
    clear_plan();
    fail_plan[5] = 4'b1000;
    pass_plan[8] = 4'b0011;
    run_test(1'b1, 0);
    // Pass beats timeout on the last allowed cycle.
    clear_plan();
    pass_plan[50] = 4'b0011;
    pass_plan[60] = 4'b1100;
    run_test(1'b0, 0);
    // Reset mid-run, then a full run after a short reset pulse.
    clear_plan();
    run_test(1'b0, 20);
    clear_plan();
    pass_plan[10] = 4'b0001;
    pass_plan[12] = 4'b0010;
    pass_plan[14] = 4'b0100;
    pass_plan[20] = 4'b1000;
    run_test(1'b1, 0);
    for (int t = 0; t < 12; t++) begin
      random_plan();
      run_test(t[0], 0);
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
